// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN inference core front end.
package snn_pkg;

    localparam int unsigned NUM_PIXELS      = 784;
    localparam int unsigned ADDR_W          = 10;
    localparam int unsigned BYTES_PER_FRAME = NUM_PIXELS / 8;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StWaitByte,
        StStart,
        StRun
    } loader_state_e;

endpackage

// File: rtl/image_loader.sv
// Unpacks UART bytes LSB-first into the 1-bit pixel RAM and starts the core once a
// full frame is written; further bytes are refused until the core reports done.
module image_loader #(
    parameter int unsigned NUM_PIXELS = snn_pkg::NUM_PIXELS,
    parameter int unsigned ADDR_W     = snn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_data,
    output logic              ram_we,
    output logic              core_start,
    input  logic              core_done,
    output logic              busy,
    output logic              overrun
);
    import snn_pkg::*;

    localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(NUM_PIXELS - 1);

    loader_state_e     state_q, state_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              overrun_d;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        bit_cnt_d  = bit_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        overrun_d  = overrun;
        unique case (state_q)
            StIdle, StWaitByte: begin
                if (rx_rdy) begin
                    shreg_d   = rx_data;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                shreg_d   = {1'b0, shreg_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                if (bit_cnt_q == 3'd7) begin
                    if (pix_cnt_q == LastPix) begin
                        // Anything still queued belongs past the frame and is lost.
                        pix_cnt_d  = '0;
                        hold_vld_d = 1'b0;
                        state_d    = StStart;
                        if (rx_rdy || hold_vld_q) begin
                            overrun_d = 1'b1;
                        end
                    end else if (hold_vld_q) begin
                        shreg_d    = hold_q;
                        hold_vld_d = rx_rdy;
                        if (rx_rdy) begin
                            hold_d = rx_data;
                        end
                    end else if (rx_rdy) begin
                        shreg_d = rx_data;
                    end else begin
                        state_d = StWaitByte;
                    end
                end else if (rx_rdy) begin
                    if (hold_vld_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        hold_d     = rx_data;
                        hold_vld_d = 1'b1;
                    end
                end
            end
            StStart: begin
                state_d = StRun;
                if (rx_rdy) begin
                    overrun_d = 1'b1;
                end
            end
            StRun: begin
                if (rx_rdy) begin
                    overrun_d = 1'b1;
                end
                if (core_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            bit_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            ram_addr   <= '0;
            ram_data   <= 1'b0;
            ram_we     <= 1'b0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            bit_cnt_q  <= bit_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            // Write port mirrors the pixel about to be shifted; address holds when idle.
            ram_we     <= (state_d == StShift);
            if (state_d == StShift) begin
                ram_data <= shreg_d[0];
                ram_addr <= pix_cnt_d;
            end
            core_start <= (state_d == StStart);
            busy       <= (state_d != StIdle);
            overrun    <= overrun_d;
        end
    end

endmodule

// File: doc/image_loader.md
# image_loader

Upstream stage of the SNN inference core. Accepts the byte stream from the UART receiver, unpacks each byte LSB-first into the 1-bit-wide, 1024-deep input-pixel RAM, and, once a full 784-pixel frame (98 bytes) is written, pulses `core_start`. It then holds off further loading until the core reports `core_done`. The top level muxes the RAM address between this block's write address and the core's read address using `ram_we`.

## Interface
Parameters:
- `NUM_PIXELS`, 784: pixels per frame; must be a multiple of 8.
- `ADDR_W`, 10: RAM address width.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte; valid only in the cycle `rx_rdy` is high.
- `rx_rdy`  in  1  single-cycle strobe: new byte available.
- `ram_addr`  out  ADDR_W  pixel write address.
- `ram_data`  out  1  pixel bit to write.
- `ram_we`  out  1  RAM write enable.
- `core_start`  out  1  single-cycle pulse: frame loaded, begin inference.
- `core_done`  in  1  single-cycle pulse from core: inference finished.
- `busy`  out  1  high from first byte accepted until `core_done`.
- `overrun`  out  1  sticky: a byte was dropped.

## Operation
- FSM states: IDLE, SHIFT, WAIT_BYTE, START, RUN.
- IDLE: on `rx_rdy`, load `rx_data` into an 8-bit shift register, clear bit counter, go to SHIFT.
- SHIFT: `ram_we`=1, `ram_data`=shreg[0], `ram_addr`=pixel counter; each cycle shift right, increment bit counter and pixel counter. After the 8th bit, go to START if pixel counter has just written `NUM_PIXELS-1`; else go to WAIT_BYTE, or directly back into SHIFT with the pending byte if one is held.
- WAIT_BYTE: on `rx_rdy`, load the byte and go to SHIFT.
- START: `core_start`=1 for one cycle; pixel counter cleared; go to RUN.
- RUN: wait for `core_done`, then go to IDLE.
- Pending byte: one-entry holding register. `rx_rdy` during SHIFT stores the byte there. If the holding register is already full, the new byte is dropped and `overrun` is set.
- `rx_rdy` in START or RUN: byte dropped and `overrun` set. Bytes are never written while the core reads the RAM.
- `core_done` outside RUN is ignored.
- Pixel address = byte_index*8 + bit_index, with bit 0 of each byte first. The counter width is ADDR_W. It never exceeds `NUM_PIXELS-1` and wraps to 0 only via START.
- `overrun` is cleared only by reset.

## Timing
- Reset values: `ram_addr`=0, `ram_data`=0, `ram_we`=0, `core_start`=0, `busy`=0, `overrun`=0. The FSM enters IDLE, counters are 0, and the holding register is empty.
- Asserting reset mid-frame discards the partial frame; the next byte after release is pixel 0.
- `rx_rdy` at cycle T produces writes at T+1 through T+8, with `ram_we` high for exactly 8 consecutive cycles.
- For the last byte, strobed at T, `core_start` is high at T+9 and `busy` stays high through the `core_done` cycle.
- `busy` rises at T+1 of the first byte and falls the cycle after `core_done`.
- `ram_addr` holds its last value when `ram_we`=0. Outputs are registered.
- `rx_rdy` in the same cycle the FSM leaves SHIFT for WAIT_BYTE: the byte is accepted, not dropped.

## Structure
- Shared package `snn_pkg`: `NUM_PIXELS`, `ADDR_W`, `BYTES_PER_FRAME` (=NUM_PIXELS/8), and the loader state enum type.
- Single module; no sub-module. The shift register and holding register are inline.

## Test plan
- Reset, then 98 bytes of 0xA5, spaced 100 cycles apart → 784 writes with the pattern 1,0,1,0,0,1,0,1 repeating; addresses 0..783; one `core_start` pulse 9 cycles after the last strobe.
- Byte 0x01, then a second `rx_rdy` 3 cycles later with 0x80 → pixel 0=1, pixels 1..14=0, pixel 15=1; 16 contiguous `ram_we` cycles; `overrun`=0.
- Three strobes within one SHIFT window → the third byte is dropped and `overrun`=1; the following writes cover only the first two bytes.
- Full frame, then `rx_rdy` during RUN → no `ram_we`, `overrun`=1. `core_done` then returns to IDLE, and the next byte writes address 0.
- Reset asserted after 50 bytes → all outputs at their reset values. A subsequent full frame loads addresses 0..783 and pulses `core_start` once.
- `core_done` pulse while IDLE → no state change and `busy` stays 0.
